// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between instruction fetch and data
// memory. Data requests take priority over fetches. Each access drives the RAM
// until it reports ACCESS or ERROR, the request is withdrawn, or the wait
// counter expires. A completed access produces a one-cycle ihit or dhit pulse.
module mem_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ACC  = 3'd1,
        D_ACC  = 3'd2,
        I_RESP = 3'd3,
        D_RESP = 3'd4
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             is_wr;     // latched data op: 1 = store
    logic             grant_d, grant_i;
    logic             acc_ok, acc_err, timed_out;
    logic             in_acc, req_held;

    // State register; reset drops any access in flight, so the decoded
    // strobes fall asynchronously with nRST.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic: data beats fetch in IDLE; an access ends on ACCESS,
    // ERROR, timeout or withdrawal of the request, in that priority order.
    always_comb begin
        next_state = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        acc_ok     = 1'b0;
        acc_err    = 1'b0;
        timed_out  = 1'b0;
        in_acc     = (state == I_ACC) || (state == D_ACC);
        req_held   = (state == D_ACC) ? (dREN | dWEN) : iREN;
        case (state)
            IDLE: begin
                if (dREN | dWEN) begin
                    grant_d    = 1'b1;
                    next_state = D_ACC;
                end else if (iREN) begin
                    grant_i    = 1'b1;
                    next_state = I_ACC;
                end
            end
            I_ACC, D_ACC: begin
                if (ramstate == RAM_ACCESS) begin
                    acc_ok     = 1'b1;
                    next_state = (state == I_ACC) ? I_RESP : D_RESP;
                end else if (ramstate == RAM_ERROR) begin
                    // Still hit so the pipeline does not stall forever.
                    acc_err    = 1'b1;
                    next_state = (state == I_ACC) ? I_RESP : D_RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th cycle spent waiting.
                    timed_out  = 1'b1;
                    next_state = IDLE;
                end else if (!req_held) begin
                    next_state = IDLE;
                end
            end
            I_RESP, D_RESP: next_state = IDLE;
            default:        next_state = IDLE;
        endcase
    end

    // Wait counter: cleared on grant, counts every cycle spent in an ACC state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                 cnt <= '0;
        else if (grant_d | grant_i) cnt <= '0;
        else if (in_acc)            cnt <= cnt + 1'b1;
    end

    // Request latch: address/data/op captured at grant and held for the whole
    // access; ramaddr/ramstore keep their last values between accesses.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ramaddr  <= '0;
            ramstore <= '0;
            is_wr    <= 1'b0;
        end else if (grant_d) begin
            ramaddr  <= daddr;
            ramstore <= dstore;
            is_wr    <= dWEN;
        end else if (grant_i) begin
            ramaddr  <= iaddr;
        end
    end

    // Load registers capture RAM data only on a successful read.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            iload <= '0;
            dload <= '0;
        end else if (acc_ok) begin
            if (state == I_ACC)  iload <= ramload;
            else if (!is_wr)     dload <= ramload;
        end
    end

    // Sticky error flag: RAM ERROR or wait-counter expiry.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                  err <= 1'b0;
        else if (acc_err | timed_out) err <= 1'b1;
    end

    assign ramREN = (state == I_ACC) || ((state == D_ACC) && !is_wr);
    assign ramWEN = (state == D_ACC) && is_wr;
    assign ihit   = (state == I_RESP);
    assign dhit   = (state == D_RESP);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-programmable RAM model plus a reference
// memory and load-register model checked at every hit.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        ihit, dhit, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [31:0] ramload  = 32'h0;
    logic [1:0]  ramstate = 2'd0;

    int errors = 0;
    int checks = 0;

    mem_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    // RAM model: BUSY for ram_wait cycles after a strobe appears, then ACCESS.
    int          ram_wait     = 0;
    bit          ram_err_mode = 1'b0;
    int          busy_cnt     = 0;
    logic [31:0] ram_mem [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Respond a little after each rising edge, from the strobes now showing.
    always @(posedge CLK) begin
        #2;
        if (ramREN || ramWEN) begin
            if (ram_err_mode) begin
                ramstate = 2'd3;
                ramload  = $urandom;
            end else if (busy_cnt < ram_wait) begin
                ramstate = 2'd1;
                busy_cnt++;
                ramload  = $urandom;
            end else begin
                ramstate = 2'd2;
                if (ramWEN) begin
                    ram_mem[ramaddr] = ramstore;
                    ramload = $urandom;
                end else begin
                    ramload = ram_mem.exists(ramaddr) ? ram_mem[ramaddr] : dflt(ramaddr);
                end
            end
        end else begin
            ramstate = 2'd0;
            busy_cnt = 0;
        end
    end

    // Reference: what memory should hold and what the load registers should show.
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] model_iload, model_dload;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ihit"},     32'(ihit),   32'd0);
        chk({tag, " dhit"},     32'(dhit),   32'd0);
        chk({tag, " ramREN"},   32'(ramREN), 32'd0);
        chk({tag, " ramWEN"},   32'(ramWEN), 32'd0);
        chk({tag, " err"},      32'(err),    32'd0);
        chk({tag, " iload"},    iload,       32'd0);
        chk({tag, " dload"},    dload,       32'd0);
        chk({tag, " ramaddr"},  ramaddr,     32'd0);
        chk({tag, " ramstore"}, ramstore,    32'd0);
    endtask

    // Follow one granted access to its hit and check it against the model.
    task automatic one_access(input bit is_d, input bit wr, input logic [31:0] a,
                              input logic [31:0] sd, input int wt, input string tag);
        int          n;
        bit          hit_i, hit_d, seen_ren, seen_wen;
        logic [31:0] seen_addr, seen_store;
        n = 0; hit_i = 0; hit_d = 0; seen_ren = 0; seen_wen = 0;
        seen_addr = 32'hx; seen_store = 32'hx;
        for (int c = 0; c < 600; c++) begin
            @(negedge CLK);
            if (ihit || dhit) begin
                hit_i = ihit;
                hit_d = dhit;
                break;
            end
            if (ramREN || ramWEN) begin
                n++;
                seen_addr  = ramaddr;
                seen_store = ramstore;
                seen_ren  |= ramREN;
                seen_wen  |= ramWEN;
                if (is_d) begin
                    daddr  = $urandom;
                    dstore = 32'h0;
                end
            end
        end
        chk({tag, " hit kind"}, 32'({hit_i, hit_d}), is_d ? 32'd1 : 32'd2);
        chk({tag, " strobe cycles"}, 32'(n), 32'(wt + 1));
        chk({tag, " ramaddr"}, seen_addr, a);
        chk({tag, " strobe type"}, 32'({seen_ren, seen_wen}), (is_d && wr) ? 32'd1 : 32'd2);
        if (is_d && wr) chk({tag, " ramstore"}, seen_store, sd);
        if (!is_d)      model_iload = ref_rd(a);
        else if (!wr)   model_dload = ref_rd(a);
        else            ref_mem[a]  = sd;
        chk({tag, " iload"}, iload, model_iload);
        chk({tag, " dload"}, dload, model_dload);
    endtask

    // Raise the requested mix in one cycle; data is expected first, then fetch.
    task automatic serve(input bit want_i, input bit want_d, input bit wr,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] ds, input int wt, input string tag);
        @(negedge CLK);
        ram_wait = wt;
        iREN   = want_i;
        iaddr  = ia;
        dREN   = want_d && !wr;
        dWEN   = want_d && wr;
        daddr  = da;
        dstore = ds;
        if (want_d) begin
            one_access(1'b1, wr, da, ds, wt, {tag, "/d"});
            dREN = 1'b0;
            dWEN = 1'b0;
        end
        if (want_i) begin
            one_access(1'b0, 1'b0, ia, 32'h0, wt, {tag, "/i"});
            iREN = 1'b0;
        end
    endtask

    initial begin
        int          n, hits, op, wt;
        logic [31:0] ia, da, ds;
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0;
        model_iload = 0; model_dload = 0;

        // Reset state
        repeat (2) @(negedge CLK);
        chk_zero("reset");
        nRST = 1'b1;
        @(negedge CLK);
        chk_zero("idle");

        // Directed: store, fetch with 2 BUSY cycles, spec store, contention
        serve(1'b0, 1'b1, 1'b1, 32'h0, 32'h40, 32'h8C220004, 0, "st40");
        serve(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 2, "fetch");
        chk("fetch iload value", iload, 32'h8C220004);
        serve(1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 32'hDEADBEEF, 1, "store");
        serve(1'b1, 1'b1, 1'b0, 32'h40, 32'h200, 32'h0, 1, "contend");
        chk("contend dload value", dload, 32'hDEADBEEF);

        // Abort: load withdrawn while RAM is BUSY
        @(negedge CLK);
        ram_wait = 100000;
        dREN  = 1'b1;
        daddr = 32'h500;
        repeat (3) @(negedge CLK);
        chk("abort strobe up", 32'(ramREN), 32'd1);
        dREN = 1'b0;
        hits = 0;
        repeat (4) begin
            @(negedge CLK);
            if (ihit || dhit) hits++;
        end
        chk("abort no hit", 32'(hits), 32'd0);
        chk("abort strobe down", 32'({ramREN, ramWEN}), 32'd0);
        chk("abort dload", dload, model_dload);
        serve(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 0, "post-abort");

        // Random mix against the reference
        for (int k = 0; k < 25; k++) begin
            op = $urandom_range(0, 3);
            wt = $urandom_range(0, 3);
            ia = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
            da = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
            ds = $urandom;
            case (op)
                0: serve(1'b1, 1'b0, 1'b0, ia, da, ds, wt, "rnd fetch");
                1: serve(1'b0, 1'b1, 1'b0, ia, da, ds, wt, "rnd load");
                2: serve(1'b0, 1'b1, 1'b1, ia, da, ds, wt, "rnd store");
                default: serve(1'b1, 1'b1, 1'($urandom_range(0, 1)), ia, da, ds, wt, "rnd both");
            endcase
        end
        chk("err clear after traffic", 32'(err), 32'd0);

        // RAM ERROR during a fetch: hit still pulses, iload untouched
        @(negedge CLK);
        ram_err_mode = 1'b1;
        iREN  = 1'b1;
        iaddr = 32'h1000;
        n = 0; hits = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge CLK);
            if (ihit || dhit) begin
                hits = {30'd0, ihit, dhit};
                break;
            end
            if (ramREN) n++;
        end
        iREN = 1'b0;
        ram_err_mode = 1'b0;
        chk("error hit kind", 32'(hits), 32'd2);
        chk("error strobe cycles", 32'(n), 32'd1);
        chk("error err flag", 32'(err), 32'd1);
        chk("error iload", iload, model_iload);

        // Reset clears the sticky flag
        @(negedge CLK);
        nRST = 1'b0;
        model_iload = 0; model_dload = 0;
        @(negedge CLK);
        chk_zero("reset2");
        nRST = 1'b1;

        // Timeout: RAM stays BUSY, access abandoned after TIMEOUT cycles
        @(negedge CLK);
        ram_wait = 100000;
        dREN  = 1'b1;
        daddr = 32'h300;
        n = 0; hits = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge CLK);
            if (ihit || dhit) hits++;
            if (ramREN || ramWEN) n++;
            else if (n > 0) break;
        end
        dREN = 1'b0;
        chk("timeout strobe cycles", 32'(n), 32'd255);
        chk("timeout no hit", 32'(hits), 32'd0);
        chk("timeout err flag", 32'(err), 32'd1);
        chk("timeout dload", dload, model_dload);

        // Reset in the middle of a store
        @(negedge CLK);
        dWEN   = 1'b1;
        daddr  = 32'h400;
        dstore = 32'h1234;
        repeat (3) @(negedge CLK);
        chk("midrst strobe up", 32'(ramWEN), 32'd1);
        @(posedge CLK);
        #3;
        nRST = 1'b0;
        dWEN = 1'b0;
        #1;
        chk("midrst async strobes", 32'({ramREN, ramWEN, dhit}), 32'd0);
        @(negedge CLK);
        model_iload = 0; model_dload = 0;
        chk_zero("midrst held");
        nRST = 1'b1;
        @(negedge CLK);
        chk_zero("midrst released");
        serve(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 1, "post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
